// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port/direction constants for the memory request arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DRAIN} state_t;
  localparam int PORT_IC = 0;
  localparam int PORT_DC = 1;
  localparam int PORT_UC = 2;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting just after the last granted index
// ports: req (request vector), last (previous winner index) -> winner (one-hot), idx, valid
module rr_picker #(
  parameter int NREQ = 3,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  // scan from farthest to nearest so the nearest set bit after last wins
  always_comb begin
    winner = '0;
    idx = '0;
    valid = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(last) + k) % NREQ]) begin
        winner = NREQ'(1) << ((int'(last) + k) % NREQ);
        idx = IW'((int'(last) + k) % NREQ);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of one AXI controller request port among NREQ requesters
// requester side: req_i/rw_i/addr_i/wdata_i/len_i/fifo_*_i in, done_o/rdata_o/grant_o out
// controller side: m_req_o/m_rw_o/m_addr_o/m_wdata_o/m_len_o/m_fifo_*_o out, m_done_i/m_rdata_i in
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   rw_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  input  logic [NREQ*8-1:0] len_i,
  input  logic [NREQ*9-1:0] fifo_idx_i,
  input  logic [NREQ-1:0]   fifo_done_i,
  input  logic [NREQ-1:0]   fifo_wen_i,
  output logic [NREQ-1:0]   done_o,
  output logic [DW-1:0]     rdata_o,
  output logic [NREQ-1:0]   grant_o,
  output logic              m_req_o,
  output logic              m_rw_o,
  output logic [AW-1:0]     m_addr_o,
  output logic [DW-1:0]     m_wdata_o,
  output logic [7:0]        m_len_o,
  input  logic              m_done_i,
  input  logic [DW-1:0]     m_rdata_i,
  output logic [8:0]        m_fifo_idx_o,
  output logic              m_fifo_done_o,
  output logic              m_fifo_wen_o
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [IW-1:0] g, last, p_idx;
  logic [NREQ-1:0] p_hot;
  logic p_valid, in_xfer;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req_i),
    .last(last),
    .winner(p_hot),
    .idx(p_idx),
    .valid(p_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      last <= IW'(NREQ - 1);
      grant_o <= '0;
      m_req_o <= 1'b0;
      m_rw_o <= 1'b0;
      m_addr_o <= '0;
      m_wdata_o <= '0;
      m_len_o <= '0;
    end else begin
      case (state)
        // a lingering m_done_i (e.g. after an abort) must clear before a new grant
        IDLE: if (p_valid && !m_done_i) begin
          g <= p_idx;
          grant_o <= p_hot;
          m_req_o <= 1'b1;
          m_rw_o <= rw_i[p_idx];
          m_addr_o <= addr_i[p_idx*AW +: AW];
          m_wdata_o <= wdata_i[p_idx*DW +: DW];
          m_len_o <= len_i[p_idx*8 +: 8];
          state <= ISSUE;
        end
        ISSUE: if (m_done_i) begin
          m_req_o <= 1'b0;
          state <= XFER;
        end
        XFER: if (fifo_done_i[g]) state <= DRAIN;
        DRAIN: if (!m_done_i) begin
          last <= g;
          grant_o <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign in_xfer = state == XFER;
  assign done_o = in_xfer && m_done_i ? grant_o : '0;
  assign rdata_o = m_rdata_i;
  assign m_fifo_idx_o = in_xfer ? fifo_idx_i[g*9 +: 9] : '0;
  assign m_fifo_done_o = in_xfer && fifo_done_i[g];
  assign m_fifo_wen_o = in_xfer && fifo_wen_i[g];
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and randomized self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req = '0, rw = '0, fdone = '0, fwen = '0;
  logic [63:0] addr [3];
  logic [63:0] wdata [3];
  logic [7:0] len [3];
  logic [8:0] fidx [3];
  logic [191:0] addr_i, wdata_i;
  logic [23:0] len_i;
  logic [26:0] fifo_idx_i;
  logic [2:0] done_o, grant_o;
  logic [63:0] rdata_o, m_addr_o, m_wdata_o, m_rdata_i = '0;
  logic m_req_o, m_rw_o, m_done_i = 1'b0, m_fifo_done_o, m_fifo_wen_o;
  logic [7:0] m_len_o;
  logic [8:0] m_fifo_idx_o;
  int vectors = 0, miscompares = 0, last_g = 2;
  always #5 clk = ~clk;
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      addr_i[k*64 +: 64] = addr[k];
      wdata_i[k*64 +: 64] = wdata[k];
      len_i[k*8 +: 8] = len[k];
      fifo_idx_i[k*9 +: 9] = fidx[k];
    end
  end
  mem_req_arbiter #(.NREQ(3), .AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst), .req_i(req), .rw_i(rw), .addr_i(addr_i), .wdata_i(wdata_i),
    .len_i(len_i), .fifo_idx_i(fifo_idx_i), .fifo_done_i(fdone), .fifo_wen_i(fwen),
    .done_o(done_o), .rdata_o(rdata_o), .grant_o(grant_o), .m_req_o(m_req_o), .m_rw_o(m_rw_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_len_o(m_len_o), .m_done_i(m_done_i),
    .m_rdata_i(m_rdata_i), .m_fifo_idx_o(m_fifo_idx_o), .m_fifo_done_o(m_fifo_done_o),
    .m_fifo_wen_o(m_fifo_wen_o)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [2:0] r, input int l);
    for (int k = 1; k <= 3; k++) if (r[(l + k) % 3]) return (l + k) % 3;
    return -1;
  endfunction
  task automatic randomize_port(input int k);
    addr[k] = {$urandom, $urandom};
    wdata[k] = {$urandom, $urandom};
    len[k] = 8'($urandom);
    rw[k] = 1'($urandom);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    m_done_i = 1'b0;
    fdone = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_grant", grant_o, 0);
    check("rst_m_req", m_req_o, 0);
    check("rst_m_rw", m_rw_o, 0);
    check("rst_m_addr", m_addr_o, 0);
    check("rst_m_wdata", m_wdata_o, 0);
    check("rst_m_len", m_len_o, 0);
    check("rst_done", done_o, 0);
    last_g = 2;
  endtask
  // One full transaction for requester eg; entered at a negedge with the DUT idle and req set.
  task automatic run_txn(input int eg, input int iw, input int xc, input int dh);
    logic [63:0] ea, ew;
    logic [7:0] el;
    logic er;
    logic [2:0] oh;
    ea = addr[eg];
    ew = wdata[eg];
    el = len[eg];
    er = rw[eg];
    oh = 3'b001 << eg;
    @(negedge clk);
    check("grant", grant_o, oh);
    check("m_req_rise", m_req_o, 1);
    check("m_addr", m_addr_o, ea);
    check("m_rw", m_rw_o, er);
    check("m_len", m_len_o, el);
    check("m_wdata", m_wdata_o, ew);
    check("done_issue", done_o, 0);
    for (int k = 0; k < 3; k++) randomize_port(k);
    req = 3'($urandom);
    repeat (iw) begin
      @(negedge clk);
      check("m_req_hold", m_req_o, 1);
      check("m_wdata_hold", m_wdata_o, ew);
      check("m_addr_hold", m_addr_o, ea);
    end
    m_done_i = 1'b1;
    @(negedge clk);
    check("m_req_fall", m_req_o, 0);
    check("grant_xfer", grant_o, oh);
    for (int c = 0; c <= xc; c++) begin
      for (int k = 0; k < 3; k++) fidx[k] = 9'($urandom);
      fwen = 3'($urandom);
      fdone = (c == xc) ? (3'($urandom) | oh) : (3'($urandom) & ~oh);
      m_rdata_i = {$urandom, $urandom};
      #1;
      check("done_xfer", done_o, oh);
      check("fifo_idx", m_fifo_idx_o, fidx[eg]);
      check("fifo_wen", m_fifo_wen_o, fwen[eg]);
      check("fifo_done", m_fifo_done_o, fdone[eg]);
      check("rdata", rdata_o, m_rdata_i);
      @(negedge clk);
    end
    fdone = '0;
    fwen = 3'b111;
    #1;
    check("done_drain", done_o, 0);
    check("grant_drain", grant_o, oh);
    check("fifo_idx_drain", m_fifo_idx_o, 0);
    check("fifo_wen_drain", m_fifo_wen_o, 0);
    check("m_req_drain", m_req_o, 0);
    repeat (dh - 1) begin
      @(negedge clk);
      check("grant_sticky", grant_o, oh);
      check("done_sticky", done_o, 0);
      check("m_req_sticky", m_req_o, 0);
    end
    m_done_i = 1'b0;
    @(negedge clk);
    check("grant_idle", grant_o, 0);
    check("m_req_idle", m_req_o, 0);
    check("done_idle", done_o, 0);
    last_g = eg;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0;
      wdata[k] = '0;
      len[k] = '0;
      fidx[k] = '0;
    end
    do_reset();
    addr[1] = 64'h8000_0040;
    len[1] = 8'd8;
    rw[1] = 1'b0;
    req = 3'b010;
    run_txn(1, 2, 3, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req = 3'b111;
      run_txn(i, 0, 1, 1);
    end
    req = 3'b101;
    run_txn(0, 1, 0, 1);
    req = 3'b101;
    run_txn(2, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      req = 3'b011;
      run_txn(i % 2, 0, 1, 2);
    end
    req = 3'b100;
    rw[2] = 1'b1;
    wdata[2] = 64'hDEAD_BEEF_0000_0001;
    len[2] = 8'd8;
    run_txn(2, 3, 1, 5);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        @(negedge clk);
        check("idle_grant", grant_o, 0);
        check("idle_m_req", m_req_o, 0);
      end
      for (int k = 0; k < 3; k++) randomize_port(k);
      req = 3'($urandom_range(1, 7));
      run_txn(pick(req, last_g), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 4));
    end
    do_reset();
    addr[0] = 64'h1234;
    req = 3'b001;
    @(negedge clk);
    check("pre_abort_grant", grant_o, 3'b001);
    m_done_i = 1'b1;
    @(negedge clk);
    check("pre_abort_done", done_o, 3'b001);
    rst = 1'b1;
    req = 3'b110;
    m_done_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_grant", grant_o, 0);
    check("abort_m_req", m_req_o, 0);
    check("abort_done", done_o, 0);
    last_g = 2;
    run_txn(1, 0, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
